lm80c_ram_arbiter: RTL and testbench

//  Shares the single external RAM port between NREQ requesters: Z80 CPU (idx 0),
//  ROM/ioctl loader (idx 1) and the SDRAM test port (idx 2). Grants one access at a

---
 rtl/lm80c_ram_arbiter_pkg.sv | 13 +
 rtl/lm80c_ram_arbiter_if.sv | 35 +++
 rtl/lm80c_prio_pick.sv | 29 ++
 rtl/lm80c_ram_arbiter.sv | 155 +++++++++++++++
 tb/tb_lm80c_ram_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lm80c_ram_arbiter_pkg.sv
// Shared types and constants for the LM80C external RAM arbiter.
package lm80c_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    // Value returned to a requester whose access timed out.
    localparam logic [7:0] RD_TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/lm80c_ram_arbiter_if.sv
// Requester-side and RAM-side bus of the arbiter; slave = arbiter, master = requesters/RAM.
interface lm80c_ram_arbiter_if #(
    parameter int AW   = 16,
    parameter int NREQ = 3
);
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         we;
    logic [NREQ-1:0][AW-1:0] addr;
    logic [NREQ-1:0][7:0]    wdata;
    logic [NREQ-1:0]         ack;
    logic [7:0]              rdata;
    logic [NREQ-1:0]         grant;
    logic                    cpu_wait;

    logic [AW-1:0]           mem_addr;
    logic [7:0]              mem_wdata;
    logic                    mem_rd;
    logic                    mem_wr;
    logic [7:0]              mem_rdata;
    logic                    mem_ready;

    logic                    err;
    logic                    err_clr;

    modport slave (
        input  req, we, addr, wdata, mem_rdata, mem_ready, err_clr,
        output ack, rdata, grant, cpu_wait, mem_addr, mem_wdata, mem_rd, mem_wr, err
    );

    modport master (
        output req, we, addr, wdata, mem_rdata, mem_ready, err_clr,
        input  ack, rdata, grant, cpu_wait, mem_addr, mem_wdata, mem_rd, mem_wr, err
    );

endinterface

// File: rtl/lm80c_prio_pick.sv
// Combinational fixed-priority picker: lowest unmasked requesting index wins.
module lm80c_prio_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        // Scan high to low so the lowest eligible index is written last and wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && !mask[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IW'(i);
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lm80c_ram_arbiter.sv
// Shares the single external RAM port between the Z80, the loader and the SDRAM test port.
module lm80c_ram_arbiter
    import lm80c_pkg::*;
#(
    parameter int AW         = 16,
    parameter int NREQ       = 3,
    parameter int FAIR_LIMIT = 8,
    parameter int TIMEOUT    = 64
) (
    input logic               sys_clock,
    input logic               RESET_n,
    lm80c_ram_arbiter_if.slave bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int FW = $clog2(FAIR_LIMIT + 1);

    arb_state_t      state, state_d;
    logic [TW-1:0]   to_cnt;
    logic [FW-1:0]   fair_cnt;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] ack_q;
    logic [AW-1:0]   mem_addr_q;
    logic [7:0]      mem_wdata_q;
    logic            mem_rd_q;
    logic            mem_wr_q;
    logic [7:0]      rdata_q;
    logic            err_q;

    logic            others_pending;
    logic            fair_mask;
    logic [NREQ-1:0] pick_mask;
    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;

    logic            start;
    logic            done_ok;
    logic            done_to;

    // Idx 0 is masked only when it has hogged FAIR_LIMIT grants and someone else waits.
    assign others_pending = |bus.req[NREQ-1:1];
    assign fair_mask      = others_pending && (fair_cnt == FW'(FAIR_LIMIT));
    assign pick_mask      = {{(NREQ-1){1'b0}}, fair_mask};

    lm80c_prio_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req    (bus.req),
        .mask   (pick_mask),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        state_d = state;
        start   = 1'b0;
        done_ok = 1'b0;
        done_to = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    start   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.mem_ready) begin
                    done_ok = 1'b1;
                    state_d = DONE;
                end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                    done_to = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clock or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge sys_clock or negedge RESET_n) begin
        if (!RESET_n) begin
            to_cnt      <= '0;
            fair_cnt    <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            ack_q <= '0;
            if (start) begin
                grant_q     <= pick_onehot;
                mem_addr_q  <= bus.addr[pick_idx];
                mem_wdata_q <= bus.wdata[pick_idx];
                mem_rd_q    <= ~bus.we[pick_idx];
                mem_wr_q    <= bus.we[pick_idx];
                to_cnt      <= '0;
                if (pick_onehot[0] && others_pending) begin
                    fair_cnt <= fair_cnt + 1'b1;
                end else begin
                    fair_cnt <= '0;
                end
            end else if (state == ACCESS) begin
                if (done_ok || done_to) begin
                    mem_rd_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                    ack_q    <= grant_q;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
                if (done_ok && mem_rd_q) begin
                    rdata_q <= bus.mem_rdata;
                end else if (done_to) begin
                    rdata_q <= RD_TIMEOUT_DATA;
                end
            end else if (state == DONE) begin
                grant_q <= '0;
            end

            // A new timeout outranks a simultaneous clear.
            if (done_to) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.ack       = ack_q;
    assign bus.grant     = grant_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.err       = err_q;
    assign bus.cpu_wait  = bus.req[0] & ~ack_q[0];

endmodule

// File: tb/tb_lm80c_ram_arbiter.sv
// Directed bench for lm80c_ram_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_lm80c_ram_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lm80c_ram_arbiter_if #(.AW(16), .NREQ(3)) bus ();

    lm80c_ram_arbiter #(
        .AW         (16),
        .NREQ       (3),
        .FAIR_LIMIT (8),
        .TIMEOUT    (64)
    ) dut (
        .sys_clock (clk),
        .RESET_n   (rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic        rdy;
        logic [7:0]  mrd;
        logic [2:0]  e_grant;
        logic [2:0]  e_ack;
        logic        e_rd;
        logic        e_wr;
        logic [7:0]  e_rdata;
        logic        e_wait;
        logic [15:0] e_addr;
    } vec_t;

    vec_t vt [12];
    logic [2:0] exp_g [10];

    int n_cmp  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  n_gr;
        int  n_wait;
        int  n_hi;
        int  wr_drop;
        bit  got;

        bus.req       = '0;
        bus.we        = '0;
        bus.addr[0]   = 16'h8000;
        bus.addr[1]   = 16'h4001;
        bus.addr[2]   = 16'hC002;
        bus.wdata[0]  = 8'h10;
        bus.wdata[1]  = 8'hA5;
        bus.wdata[2]  = 8'h20;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        bus.err_clr   = 1'b0;

        // req, we, rdy, mrd | grant, ack, rd, wr, rdata, wait, mem_addr
        vt[0]  = '{3'b001, 3'b000, 1'b0, 8'h00, 3'b001, 3'b000, 1'b1, 1'b0, 8'h00, 1'b1, 16'h8000};
        vt[1]  = '{3'b001, 3'b000, 1'b1, 8'h5A, 3'b001, 3'b001, 1'b0, 1'b0, 8'h5A, 1'b0, 16'h8000};
        vt[2]  = '{3'b000, 3'b000, 1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 1'b0, 8'h5A, 1'b0, 16'h8000};
        vt[3]  = '{3'b111, 3'b010, 1'b0, 8'h00, 3'b001, 3'b000, 1'b1, 1'b0, 8'h5A, 1'b1, 16'h8000};
        vt[4]  = '{3'b111, 3'b010, 1'b1, 8'h11, 3'b001, 3'b001, 1'b0, 1'b0, 8'h11, 1'b0, 16'h8000};
        vt[5]  = '{3'b110, 3'b010, 1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 1'b0, 8'h11, 1'b0, 16'h8000};
        vt[6]  = '{3'b110, 3'b010, 1'b0, 8'h00, 3'b010, 3'b000, 1'b0, 1'b1, 8'h11, 1'b0, 16'h4001};
        vt[7]  = '{3'b110, 3'b010, 1'b1, 8'h77, 3'b010, 3'b010, 1'b0, 1'b0, 8'h11, 1'b0, 16'h4001};
        vt[8]  = '{3'b100, 3'b010, 1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 1'b0, 8'h11, 1'b0, 16'h4001};
        vt[9]  = '{3'b100, 3'b010, 1'b0, 8'h00, 3'b100, 3'b000, 1'b1, 1'b0, 8'h11, 1'b0, 16'hC002};
        vt[10] = '{3'b100, 3'b010, 1'b1, 8'h3C, 3'b100, 3'b100, 1'b0, 1'b0, 8'h3C, 1'b0, 16'hC002};
        vt[11] = '{3'b000, 3'b000, 1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 1'b0, 8'h3C, 1'b0, 16'hC002};

        exp_g = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_ack", 32'(bus.ack), 32'h0);
        check("rst_rd", 32'(bus.mem_rd), 32'h0);
        check("rst_wr", 32'(bus.mem_wr), 32'h0);
        check("rst_rdata", 32'(bus.rdata), 32'h0);
        check("rst_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_wait", 32'(bus.cpu_wait), 32'h0);
        rst_n = 1'b1;

        // Single CPU read, then three-way contention, one cycle per vector
        for (int i = 0; i < 12; i++) begin
            bus.req       = vt[i].req;
            bus.we        = vt[i].we;
            bus.mem_ready = vt[i].rdy;
            bus.mem_rdata = vt[i].mrd;
            step();
            check($sformatf("v%0d_grant", i), 32'(bus.grant), 32'(vt[i].e_grant));
            check($sformatf("v%0d_ack", i), 32'(bus.ack), 32'(vt[i].e_ack));
            check($sformatf("v%0d_rd", i), 32'(bus.mem_rd), 32'(vt[i].e_rd));
            check($sformatf("v%0d_wr", i), 32'(bus.mem_wr), 32'(vt[i].e_wr));
            check($sformatf("v%0d_rdata", i), 32'(bus.rdata), 32'(vt[i].e_rdata));
            check($sformatf("v%0d_wait", i), 32'(bus.cpu_wait), 32'(vt[i].e_wait));
            check($sformatf("v%0d_addr", i), 32'(bus.mem_addr), 32'(vt[i].e_addr));
        end

        // Fairness: idx 0 re-requests continuously while idx 1 waits
        bus.req       = 3'b011;
        bus.we        = 3'b000;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 8'h42;
        n_gr = 0;
        got  = 1'b0;
        for (int cyc = 0; cyc < 100 && !got; cyc++) begin
            step();
            if (bus.mem_rd && bus.grant != 3'b000 && n_gr < 10) begin
                check($sformatf("fair_grant%0d", n_gr), 32'(bus.grant), 32'(exp_g[n_gr]));
                n_gr++;
            end
            if (bus.ack[1]) bus.req[1] = 1'b0;
            if (bus.ack != 3'b000 && n_gr >= 10) begin
                bus.req = 3'b000;
                got     = 1'b1;
            end
        end
        check("fair_complete", 32'(got), 32'h1);
        bus.mem_ready = 1'b0;
        step();

        // Loader write with mem_ready withheld until timeout
        bus.req      = 3'b010;
        bus.we       = 3'b010;
        bus.addr[1]  = 16'h0123;
        bus.wdata[1] = 8'hC3;
        step();
        check("to_grant", 32'(bus.grant), 32'h2);
        check("to_wr", 32'(bus.mem_wr), 32'h1);
        check("to_addr", 32'(bus.mem_addr), 32'h0123);
        check("to_wdata", 32'(bus.mem_wdata), 32'hC3);
        n_wait  = 0;
        wr_drop = 0;
        got     = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            n_wait++;
            if (bus.ack != 3'b000) got = 1'b1;
            else if (!bus.mem_wr) wr_drop++;
        end
        check("to_latency", 32'(n_wait), 32'd64);
        check("to_wr_held", 32'(wr_drop), 32'd0);
        check("to_ack", 32'(bus.ack), 32'h2);
        check("to_err", 32'(bus.err), 32'h1);
        check("to_rdata", 32'(bus.rdata), 32'hFF);
        check("to_wr_drop", 32'(bus.mem_wr), 32'h0);
        bus.req = 3'b000;
        bus.we  = 3'b000;
        step();
        check("to_err_sticky", 32'(bus.err), 32'h1);
        check("to_grant_clr", 32'(bus.grant), 32'h0);
        bus.err_clr = 1'b1;
        step();
        check("err_clr", 32'(bus.err), 32'h0);
        bus.err_clr = 1'b0;

        // Reset in the middle of an access
        bus.req     = 3'b001;
        bus.we      = 3'b000;
        bus.addr[0] = 16'h1234;
        step();
        check("mr_rd", 32'(bus.mem_rd), 32'h1);
        check("mr_grant", 32'(bus.grant), 32'h1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_rd_drop", 32'(bus.mem_rd), 32'h0);
        check("mr_wr_drop", 32'(bus.mem_wr), 32'h0);
        check("mr_grant_drop", 32'(bus.grant), 32'h0);
        check("mr_ack", 32'(bus.ack), 32'h0);
        step();
        step();
        check("mr_ack_held", 32'(bus.ack), 32'h0);
        rst_n = 1'b1;
        step();
        check("mr_regrant", 32'(bus.grant), 32'h1);
        check("mr_regrant_rd", 32'(bus.mem_rd), 32'h1);
        check("mr_regrant_addr", 32'(bus.mem_addr), 32'h1234);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 8'h99;
        step();
        check("mr_ack_after", 32'(bus.ack), 32'h1);
        check("mr_rdata", 32'(bus.rdata), 32'h99);
        bus.req       = 3'b000;
        bus.mem_ready = 1'b0;
        step();

        // CPU write, mem_ready delayed by five cycles
        bus.req      = 3'b001;
        bus.we       = 3'b001;
        bus.addr[0]  = 16'h2222;
        bus.wdata[0] = 8'h6B;
        step();
        n_hi = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.mem_wr) n_hi++;
            check($sformatf("dw_addr%0d", i), 32'(bus.mem_addr), 32'h2222);
            check($sformatf("dw_wdata%0d", i), 32'(bus.mem_wdata), 32'h6B);
            check($sformatf("dw_wait%0d", i), 32'(bus.cpu_wait), 32'h1);
            bus.mem_ready = (i == 5);
            step();
        end
        check("dw_strobe_cycles", 32'(n_hi), 32'd6);
        check("dw_ack", 32'(bus.ack), 32'h1);
        check("dw_wr_drop", 32'(bus.mem_wr), 32'h0);
        check("dw_rdata_kept", 32'(bus.rdata), 32'h99);
        check("dw_wait_low", 32'(bus.cpu_wait), 32'h0);
        bus.req       = 3'b000;
        bus.we        = 3'b000;
        bus.mem_ready = 1'b0;
        step();
        check("dw_idle_grant", 32'(bus.grant), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule
